// File: rtl/lsu_bus_interface.sv
// Load/store unit bus front-end: turns one decoded load/store into a single-beat
// word bus transaction, extends load data, and flags misalignment and bus timeouts.
module lsu_bus_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_write,
  input  logic        memtoreg,
  input  logic [2:0]  mem_load_type,
  input  logic [1:0]  mem_store_type,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        resp_valid,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [2:0]  ltype_q, ltype_d;
  logic [1:0]  alo_q, alo_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] ldata_q, ldata_d;
  logic        mis_q, mis_d;
  logic        err_q, err_d;
  logic [31:0] cnt_q, cnt_d;

  logic        mis_now;
  logic [3:0]  be_now;
  logic [31:0] wdata_now;

  function automatic logic [31:0] extract(input logic [31:0] rdata, input logic [2:0] lt,
                                          input logic [1:0] lo);
    logic [31:0] w;
    w = rdata >> {lo, 3'b000};
    case (lt)
      3'b000:  extract = {{24{w[7]}}, w[7:0]};
      3'b001:  extract = {{16{w[15]}}, w[15:0]};
      3'b011:  extract = {24'h0, w[7:0]};
      3'b100:  extract = {16'h0, w[15:0]};
      default: extract = rdata;
    endcase
  endfunction

  // Lane selection and alignment check for the request currently on the inputs.
  always_comb begin
    be_now    = 4'b1111;
    wdata_now = 32'h0;
    mis_now   = 1'b0;
    if (mem_write) begin
      case (mem_store_type)
        2'b00: begin
          be_now    = 4'b0001 << addr[1:0];
          wdata_now = {4{store_data[7:0]}};
        end
        2'b01: begin
          be_now    = addr[1] ? 4'b1100 : 4'b0011;
          wdata_now = {2{store_data[15:0]}};
          mis_now   = addr[0];
        end
        default: begin
          wdata_now = store_data;
          mis_now   = |addr[1:0];
        end
      endcase
    end else begin
      case (mem_load_type)
        3'b000, 3'b011: mis_now = 1'b0;
        3'b001, 3'b100: mis_now = addr[0];
        default:        mis_now = |addr[1:0];
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    ltype_d = ltype_q;
    alo_d   = alo_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    ldata_d = ldata_q;
    mis_d   = mis_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 32'h0;
        if (req_valid && (mem_write || memtoreg)) begin
          ltype_d = mem_load_type;
          alo_d   = addr[1:0];
          mis_d   = mis_now;
          ldata_d = 32'h0;
          err_d   = 1'b0;
          if (mis_now) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            we_d    = mem_write;
            addr_d  = {addr[31:2], 2'b00};
            be_d    = be_now;
            wdata_d = wdata_now;
          end
        end
      end
      StWait: begin
        // Ack takes priority over a timeout landing on the same cycle.
        if (bus_ack) begin
          state_d = StResp;
          if (!we_q) ldata_d = extract(bus_rdata, ltype_q, alo_q);
        end else if (TIMEOUT_CYCLES != 0 && cnt_q == TIMEOUT_CYCLES - 1) begin
          state_d = StResp;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 32'h1;
        end
      end
      StResp: begin
        state_d = StIdle;
        cnt_d   = 32'h0;
        ldata_d = 32'h0;
        mis_d   = 1'b0;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ltype_q <= 3'h0;
      alo_q   <= 2'h0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      be_q    <= 4'h0;
      wdata_q <= 32'h0;
      ldata_q <= 32'h0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      ltype_q <= ltype_d;
      alo_q   <= alo_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign bus_req    = (state_q == StWait);
  assign resp_valid = (state_q == StResp);
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_be     = be_q;
  assign bus_wdata  = wdata_q;
  assign load_data  = ldata_q;
  assign misaligned = mis_q;
  assign bus_err    = err_q;

endmodule

// File: tb/tb_lsu_bus_interface.sv
// Directed testbench for lsu_bus_interface: loads, stores, misalignment, timeout, reset.
module tb_lsu_bus_interface;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        mem_write = 1'b0;
  logic        memtoreg = 1'b0;
  logic [2:0]  mem_load_type = 3'h0;
  logic [1:0]  mem_store_type = 2'h0;
  logic [31:0] addr = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;
  logic        resp_valid;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;
  logic        busy;

  int tests = 0;
  int fails = 0;

  lsu_bus_interface #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .mem_write(mem_write), .memtoreg(memtoreg), .mem_load_type(mem_load_type),
    .mem_store_type(mem_store_type), .addr(addr), .store_data(store_data),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
    .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
    .resp_valid(resp_valid), .load_data(load_data), .misaligned(misaligned),
    .bus_err(bus_err), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  // Presents a request for one cycle; returns just after the accepting edge.
  task automatic start_req(input logic we, input logic mr, input logic [2:0] lt,
                           input logic [1:0] st, input logic [31:0] a, input logic [31:0] sd);
    @(negedge clk);
    req_valid = 1'b1; mem_write = we; memtoreg = mr;
    mem_load_type = lt; mem_store_type = st; addr = a; store_data = sd;
    @(posedge clk);
    #1;
    req_valid = 1'b0; mem_write = 1'b0; memtoreg = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if ({bus_req, bus_we, resp_valid, misaligned, bus_err, busy} !== 6'b0 ||
        bus_addr !== 32'h0 || bus_be !== 4'h0 || bus_wdata !== 32'h0 || load_data !== 32'h0) begin
      fails++;
      $display("FAIL reset_outputs: got req=%b we=%b rv=%b mis=%b err=%b busy=%b addr=%h be=%b wd=%h ld=%h, required all 0",
               bus_req, bus_we, resp_valid, misaligned, bus_err, busy, bus_addr, bus_be,
               bus_wdata, load_data);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: got %b, required 1", req_ready);
    end
  endtask

  task automatic test_loads;
    logic [2:0]  lt [8] = '{3'b011, 3'b000, 3'b001, 3'b100, 3'b010, 3'b000, 3'b000, 3'b111};
    logic [31:0] ad [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h300, 32'h100, 32'h101,
                            32'h104};
    logic [31:0] rd [8] = '{32'h80AB_CD12, 32'h80AB_CD12, 32'h80AB_CD12, 32'h80AB_CD12,
                            32'hDEAD_BEEF, 32'h80AB_CD12, 32'h80AB_CD12, 32'h1357_9BDF};
    logic [31:0] ex [8] = '{32'h0000_0080, 32'hFFFF_FF80, 32'hFFFF_80AB, 32'h0000_80AB,
                            32'hDEAD_BEEF, 32'h0000_0012, 32'hFFFF_FFCD, 32'h1357_9BDF};
    for (int i = 0; i < 8; i++) begin
      start_req(1'b0, 1'b1, lt[i], 2'b00, ad[i], 32'h0);
      @(negedge clk);
      tests++;
      if (bus_req !== 1'b1 || bus_we !== 1'b0 || bus_be !== 4'b1111 ||
          bus_addr !== {ad[i][31:2], 2'b00} || resp_valid !== 1'b0) begin
        fails++;
        $display("FAIL load%0d_bus: got req=%b we=%b be=%b addr=%h rv=%b, required 1 0 1111 %h 0",
                 i, bus_req, bus_we, bus_be, bus_addr, resp_valid, {ad[i][31:2], 2'b00});
      end
      bus_ack = 1'b1; bus_rdata = rd[i];
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = 32'h0;
      tests++;
      if (resp_valid !== 1'b1 || load_data !== ex[i] || misaligned !== 1'b0 ||
          bus_err !== 1'b0 || bus_req !== 1'b0) begin
        fails++;
        $display("FAIL load%0d_resp: got rv=%b data=%h mis=%b err=%b req=%b, required 1 %h 0 0 0",
                 i, resp_valid, load_data, misaligned, bus_err, bus_req, ex[i]);
      end
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0) begin
        fails++;
        $display("FAIL load%0d_done: got rv=%b ready=%b busy=%b, required 0 1 0",
                 i, resp_valid, req_ready, busy);
      end
    end
  endtask

  task automatic test_stores;
    logic [1:0]  st [4] = '{2'b01, 2'b00, 2'b10, 2'b11};
    logic [31:0] ad [4] = '{32'h202, 32'h201, 32'h204, 32'h20B};
    logic [31:0] sd [4] = '{32'h1234_5678, 32'hAABB_CC99, 32'hCAFE_F00D, 32'h0};
    logic [3:0]  be [4] = '{4'b1100, 4'b0010, 4'b1111, 4'b1111};
    logic [31:0] wd [4] = '{32'h5678_5678, 32'h9999_9999, 32'hCAFE_F00D, 32'h0};
    logic [31:0] ba [4] = '{32'h200, 32'h200, 32'h204, 32'h208};
    // Last entry is SW type 11 at an aligned address with both mem_write and memtoreg set.
    ad[3] = 32'h208; sd[3] = 32'h0102_0304; wd[3] = 32'h0102_0304;
    for (int i = 0; i < 4; i++) begin
      start_req(1'b1, (i == 3), 3'b010, st[i], ad[i], sd[i]);
      @(negedge clk);
      tests++;
      if (bus_req !== 1'b1 || bus_we !== 1'b1 || bus_be !== be[i] || bus_wdata !== wd[i] ||
          bus_addr !== ba[i]) begin
        fails++;
        $display("FAIL store%0d_bus: got req=%b we=%b be=%b wd=%h addr=%h, required 1 1 %b %h %h",
                 i, bus_req, bus_we, bus_be, bus_wdata, bus_addr, be[i], wd[i], ba[i]);
      end
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      @(negedge clk);
      bus_ack = 1'b0;
      tests++;
      if (resp_valid !== 1'b1 || load_data !== 32'h0 || bus_err !== 1'b0) begin
        fails++;
        $display("FAIL store%0d_resp: got rv=%b data=%h err=%b, required 1 0 0",
                 i, resp_valid, load_data, bus_err);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_misaligned;
    logic        we [3] = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  lt [3] = '{3'b010, 3'b000, 3'b100};
    logic [1:0]  st [3] = '{2'b00, 2'b01, 2'b00};
    logic [31:0] ad [3] = '{32'h301, 32'h203, 32'h105};
    for (int i = 0; i < 3; i++) begin
      start_req(we[i], !we[i], lt[i], st[i], ad[i], 32'hFFFF_FFFF);
      @(negedge clk);
      tests++;
      if (bus_req !== 1'b0 || resp_valid !== 1'b1 || misaligned !== 1'b1 ||
          load_data !== 32'h0 || bus_err !== 1'b0) begin
        fails++;
        $display("FAIL mis%0d_resp: got req=%b rv=%b mis=%b data=%h err=%b, required 0 1 1 0 0",
                 i, bus_req, resp_valid, misaligned, load_data, bus_err);
      end
      @(negedge clk);
      tests++;
      if (resp_valid !== 1'b0 || misaligned !== 1'b0 || bus_req !== 1'b0) begin
        fails++;
        $display("FAIL mis%0d_after: got rv=%b mis=%b req=%b, required 0 0 0",
                 i, resp_valid, misaligned, bus_req);
      end
    end
  endtask

  task automatic test_timeout;
    int req_cycles = 0;
    start_req(1'b1, 1'b0, 3'b000, 2'b10, 32'h400, 32'h1111_2222);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (resp_valid) break;
      if (bus_req) req_cycles++;
    end
    tests++;
    if (req_cycles != 4 || resp_valid !== 1'b1 || bus_err !== 1'b1 || misaligned !== 1'b0) begin
      fails++;
      $display("FAIL timeout: got req_cycles=%0d rv=%b err=%b mis=%b, required 4 1 1 0",
               req_cycles, resp_valid, bus_err, misaligned);
    end
    @(negedge clk);
    tests++;
    if (bus_err !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL timeout_after: got err=%b rv=%b ready=%b, required 0 0 1",
               bus_err, resp_valid, req_ready);
    end
  endtask

  task automatic test_ack_at_timeout;
    start_req(1'b0, 1'b1, 3'b010, 2'b00, 32'h500, 32'h0);
    repeat (3) @(negedge clk);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hA5A5_0F0F;
    @(negedge clk);
    bus_ack = 1'b0;
    tests++;
    if (resp_valid !== 1'b1 || bus_err !== 1'b0 || load_data !== 32'hA5A5_0F0F) begin
      fails++;
      $display("FAIL ack_at_timeout: got rv=%b err=%b data=%h, required 1 0 a5a50f0f",
               resp_valid, bus_err, load_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    start_req(1'b1, 1'b0, 3'b000, 2'b10, 32'h600, 32'h7777_8888);
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b1) begin
      fails++;
      $display("FAIL rst_mid_pre: got req=%b, required 1", bus_req);
    end
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (bus_req !== 1'b0 || resp_valid !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid: got req=%b rv=%b busy=%b, required 0 0 0", bus_req, resp_valid, busy);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_after: got ready=%b rv=%b, required 1 0", req_ready, resp_valid);
    end
  endtask

  task automatic test_busy_ignore;
    start_req(1'b0, 1'b1, 3'b010, 2'b00, 32'h700, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; mem_write = 1'b1; mem_store_type = 2'b10; addr = 32'h800;
    tests++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL busy_flags: got ready=%b busy=%b, required 0 1", req_ready, busy);
    end
    bus_ack = 1'b1; bus_rdata = 32'h0BAD_CAFE;
    @(negedge clk);
    bus_ack = 1'b0;
    req_valid = 1'b0; mem_write = 1'b0;
    tests++;
    if (resp_valid !== 1'b1 || load_data !== 32'h0BAD_CAFE || bus_addr !== 32'h700) begin
      fails++;
      $display("FAIL busy_resp: got rv=%b data=%h addr=%h, required 1 0badcafe 00000700",
               resp_valid, load_data, bus_addr);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus_req !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL busy_not_queued: got busy=%b req=%b rv=%b, required 0 0 0",
               busy, bus_req, resp_valid);
    end
  endtask

  task automatic test_no_access;
    start_req(1'b0, 1'b0, 3'b010, 2'b10, 32'h900, 32'h0);
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || bus_req !== 1'b0 || resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL no_access: got busy=%b req=%b rv=%b, required 0 0 0",
               busy, bus_req, resp_valid);
    end
  endtask

  initial begin
    test_reset();
    test_loads();
    test_stores();
    test_misaligned();
    test_timeout();
    test_ack_at_timeout();
    test_reset_mid();
    test_busy_ignore();
    test_no_access();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
